stochastic_adc_offset_cal: RTL and testbench

Background offset-trim sequencer for one stochastic ADC slice. Runs on the slice's `clk_adder` domain and consumes the Wallace-adder result (`adder_out`, `sign_out`). Averages the signed conversion result over a programmable number of samples and steps the P-side V2T trim code until the mean falls inside a dead band. Its `ctl_v2t_p`/`ctl_v2t_n` outputs drive the slice's V2T trim inputs directly.

---
 rtl/stochastic_adc_offset_cal.sv | 238 +++++++++++++++++++++++
 tb/tb_stochastic_adc_offset_cal.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stochastic_adc_offset_cal.sv
`default_nettype none
// ============================================================================
//  Module      : stochastic_adc_offset_cal
//  Description : Background offset-trim sequencer for one stochastic ADC
//                slice. It averages the signed adder result and steps the
//                P-side V2T trim code until the mean falls inside a dead band.
//  Revision    : 1.0 - initial release
// ============================================================================
module stochastic_adc_offset_cal #(
    parameter int Nadc     = 8,
    parameter int Nctl_v2t = 5,
    parameter int Navg_max = 10,
    parameter int Nflip    = 3
) (
    input  logic                clk_adder,
    input  logic                rstb,
    input  logic                start,
    input  logic                abort,
    input  logic [Nadc-1:0]     adder_out,
    input  logic                sign_out,
    input  logic [Nctl_v2t-1:0] init_ctl_p,
    input  logic [Nctl_v2t-1:0] init_ctl_n,
    input  logic [3:0]          avg_log2,
    input  logic [7:0]          settle_cycles,
    input  logic [Nadc-1:0]     deadband,
    input  logic [7:0]          max_iter,
    output logic [Nctl_v2t-1:0] ctl_v2t_p,
    output logic [Nctl_v2t-1:0] ctl_v2t_n,
    output logic                busy,
    output logic                done,
    output logic                cal_err,
    output logic [Nadc:0]       mean_out
);

    localparam int ACC_W  = Nadc + 1 + Navg_max;
    localparam int CNT_W  = Navg_max + 1;
    localparam int FLIP_W = $clog2(Nflip + 1);

    localparam logic [3:0]          C_AVG_MAX  = 4'(Navg_max);
    localparam logic [FLIP_W-1:0]   C_NFLIP    = FLIP_W'(Nflip);
    localparam logic [Nctl_v2t-1:0] C_CODE_MAX = '1;
    localparam logic [Nctl_v2t-1:0] C_CODE_ONE = Nctl_v2t'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_ACCUM  = 3'd3,
        S_DECIDE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                     r_state;
    logic [Nctl_v2t-1:0]        r_ctl_p;
    logic [Nctl_v2t-1:0]        r_ctl_n;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_cal_err;
    logic signed [Nadc:0]       r_mean;
    logic signed [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]           r_acc_cnt;
    logic [7:0]                 r_settle_cnt;
    logic [3:0]                 r_avg_log2;
    logic [7:0]                 r_iter;
    logic [FLIP_W-1:0]          r_flip;
    logic                       r_dir_down;
    logic                       r_dir_valid;

    logic [3:0]                 w_avg_clamped;
    logic [3:0]                 w_len_sel;
    logic [CNT_W-1:0]           w_acc_len_m1;
    logic signed [Nadc:0]       w_mag;
    logic signed [Nadc:0]       w_sample;
    logic signed [ACC_W-1:0]    w_sample_ext;
    logic signed [ACC_W-1:0]    w_acc_sum;
    logic signed [Nadc:0]       w_mean;
    logic signed [Nadc+1:0]     w_mean_ext;
    logic signed [Nadc+1:0]     w_db_pos;
    logic signed [Nadc+1:0]     w_db_neg;
    logic                       w_above;
    logic                       w_below;
    logic                       w_sat;
    logic [Nctl_v2t-1:0]        w_step_p;
    logic [FLIP_W-1:0]          w_flip_next;
    logic [7:0]                 w_iter_next;
    logic                       w_flip_hit;
    logic                       w_iter_hit;

    assign w_avg_clamped = (avg_log2 > C_AVG_MAX) ? C_AVG_MAX : avg_log2;

    // LOAD may jump straight into ACCUM before r_avg_log2 has been captured
    assign w_len_sel    = (r_state == S_LOAD) ? w_avg_clamped : r_avg_log2;
    assign w_acc_len_m1 = (CNT_W'(1) << w_len_sel) - CNT_W'(1);

    assign w_mag        = {1'b0, adder_out};
    assign w_sample     = sign_out ? w_mag : -w_mag;
    assign w_sample_ext = {{(ACC_W-Nadc-1){w_sample[Nadc]}}, w_sample};
    assign w_acc_sum    = r_acc + w_sample_ext;

    // Arithmetic shift rounds toward minus infinity; result always fits Nadc+1
    assign w_mean     = (Nadc+1)'(r_acc >>> r_avg_log2);
    assign w_mean_ext = {w_mean[Nadc], w_mean};
    assign w_db_pos   = {2'b00, deadband};
    assign w_db_neg   = -w_db_pos;
    assign w_above    = (w_mean_ext > w_db_pos);
    assign w_below    = (w_mean_ext < w_db_neg);

    assign w_sat = (w_above && (r_ctl_p == '0)) ||
                   (w_below && (r_ctl_p == C_CODE_MAX));
    assign w_step_p = w_above ? (r_ctl_p - C_CODE_ONE) : (r_ctl_p + C_CODE_ONE);

    assign w_flip_next = (r_dir_valid && (r_dir_down != w_above)) ?
                         (r_flip + FLIP_W'(1)) : '0;
    assign w_iter_next = r_iter + 8'd1;
    assign w_flip_hit  = (w_flip_next >= C_NFLIP);
    assign w_iter_hit  = (max_iter != 8'd0) && (w_iter_next == max_iter);

    always_ff @(posedge clk_adder or negedge rstb) begin
        if (!rstb) begin
            r_state      <= S_IDLE;
            r_ctl_p      <= '0;
            r_ctl_n      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cal_err    <= 1'b0;
            r_mean       <= '0;
            r_acc        <= '0;
            r_acc_cnt    <= '0;
            r_settle_cnt <= '0;
            r_avg_log2   <= '0;
            r_iter       <= '0;
            r_flip       <= '0;
            r_dir_down   <= 1'b0;
            r_dir_valid  <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_ctl_p     <= init_ctl_p;
                    r_ctl_n     <= init_ctl_n;
                    r_iter      <= '0;
                    r_flip      <= '0;
                    r_dir_down  <= 1'b0;
                    r_dir_valid <= 1'b0;
                    r_cal_err   <= 1'b0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b1;
                    r_avg_log2  <= w_avg_clamped;
                    if (settle_cycles == 8'd0) begin
                        r_state   <= S_ACCUM;
                        r_acc     <= '0;
                        r_acc_cnt <= w_acc_len_m1;
                    end else begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= settle_cycles - 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt == 8'd0) begin
                        r_state   <= S_ACCUM;
                        r_acc     <= '0;
                        r_acc_cnt <= w_acc_len_m1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_acc_sum;
                    if (r_acc_cnt == '0) begin
                        r_state <= S_DECIDE;
                    end else begin
                        r_acc_cnt <= r_acc_cnt - CNT_W'(1);
                    end
                end
                S_DECIDE: begin
                    r_mean <= w_mean;
                    if (!w_above && !w_below) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_cal_err <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (w_sat) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_cal_err <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_ctl_p     <= w_step_p;
                        r_dir_down  <= w_above;
                        r_dir_valid <= 1'b1;
                        r_flip      <= w_flip_next;
                        r_iter      <= w_iter_next;
                        if (w_flip_hit || w_iter_hit) begin
                            // Oscillating around the target counts as converged
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_cal_err <= !w_flip_hit;
                            r_busy    <= 1'b0;
                        end else if (settle_cycles == 8'd0) begin
                            r_state   <= S_ACCUM;
                            r_acc     <= '0;
                            r_acc_cnt <= w_acc_len_m1;
                        end else begin
                            r_state      <= S_SETTLE;
                            r_settle_cnt <= settle_cycles - 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ctl_v2t_p = r_ctl_p;
    assign ctl_v2t_n = r_ctl_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cal_err   = r_cal_err;
    assign mean_out  = r_mean;

endmodule
`default_nettype wire

// File: tb/tb_stochastic_adc_offset_cal.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stochastic_adc_offset_cal
//  Description : Directed self-checking bench for the offset-trim sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stochastic_adc_offset_cal;

    logic       clk_adder;
    logic       rstb;
    logic       start;
    logic       abort;
    logic [7:0] adder_out;
    logic       sign_out;
    logic [4:0] init_ctl_p;
    logic [4:0] init_ctl_n;
    logic [3:0] avg_log2;
    logic [7:0] settle_cycles;
    logic [7:0] deadband;
    logic [7:0] max_iter;
    logic [4:0] ctl_v2t_p;
    logic [4:0] ctl_v2t_n;
    logic       busy;
    logic       done;
    logic       cal_err;
    logic [8:0] mean_out;

    int n_err;
    int n_chk;
    int cyc;

    // Input model: 0 = constant, 1 = offset s = 4*(p-10), 2 = sign from p parity
    int         mode;
    logic [7:0] const_mag;
    logic       const_sign;
    int         off_val;

    stochastic_adc_offset_cal dut (
        .clk_adder     (clk_adder),
        .rstb          (rstb),
        .start         (start),
        .abort         (abort),
        .adder_out     (adder_out),
        .sign_out      (sign_out),
        .init_ctl_p    (init_ctl_p),
        .init_ctl_n    (init_ctl_n),
        .avg_log2      (avg_log2),
        .settle_cycles (settle_cycles),
        .deadband      (deadband),
        .max_iter      (max_iter),
        .ctl_v2t_p     (ctl_v2t_p),
        .ctl_v2t_n     (ctl_v2t_n),
        .busy          (busy),
        .done          (done),
        .cal_err       (cal_err),
        .mean_out      (mean_out)
    );

    initial clk_adder = 1'b0;
    always #5 clk_adder = ~clk_adder;

    always_comb begin
        off_val   = 4 * (int'(ctl_v2t_p) - 10);
        adder_out = const_mag;
        sign_out  = const_sign;
        if (mode == 1) begin
            sign_out  = (off_val >= 0);
            adder_out = 8'((off_val >= 0) ? off_val : -off_val);
        end else if (mode == 2) begin
            sign_out  = ~ctl_v2t_p[0];
            adder_out = 8'd20;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_adder);
        #1;
    endtask

    task automatic kick();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Returns the edge index (start edge = 1) after which done is seen high
    task automatic wait_done(input int budget, output int c);
        tick(1);
        c = 2;
        while (!done && c < budget) begin
            tick(1);
            c++;
        end
    endtask

    task automatic setup(input int m, input logic [7:0] mag, input logic sgn,
                         input logic [4:0] p0, input logic [3:0] al,
                         input logic [7:0] st, input logic [7:0] db,
                         input logic [7:0] mi);
        mode = m; const_mag = mag; const_sign = sgn;
        init_ctl_p = p0; init_ctl_n = 5'd9; avg_log2 = al;
        settle_cycles = st; deadband = db; max_iter = mi;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        tick(2);
        n_chk++; if (ctl_v2t_p !== 5'd0) begin n_err++; $display("FAIL reset_p: got %0d expected 0", ctl_v2t_p); end
        n_chk++; if (ctl_v2t_n !== 5'd0) begin n_err++; $display("FAIL reset_n: got %0d expected 0", ctl_v2t_n); end
        n_chk++; if ({busy, done, cal_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {busy, done, cal_err}); end
        n_chk++; if (mean_out !== 9'd0) begin n_err++; $display("FAIL reset_mean: got %h expected 000", mean_out); end
        rstb = 1'b1;
        tick(3);
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_constant_step();
        setup(0, 8'd20, 1'b1, 5'd16, 4'd2, 8'd3, 8'd4, 8'd0);
        kick();
        tick(1);
        n_chk++; if (ctl_v2t_p !== 5'd16) begin n_err++; $display("FAIL load_p: got %0d expected 16", ctl_v2t_p); end
        n_chk++; if (ctl_v2t_n !== 5'd9) begin n_err++; $display("FAIL load_n: got %0d expected 9", ctl_v2t_n); end
        n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL load_busy: got %b expected 1", busy); end
        tick(7);
        n_chk++; if (ctl_v2t_p !== 5'd16) begin n_err++; $display("FAIL pre_step_p: got %0d expected 16", ctl_v2t_p); end
        tick(1);
        n_chk++; if (ctl_v2t_p !== 5'd15) begin n_err++; $display("FAIL step1_p: got %0d expected 15", ctl_v2t_p); end
        n_chk++; if (mean_out !== 9'd20) begin n_err++; $display("FAIL step1_mean: got %0d expected 20", mean_out); end
        tick(8);
        n_chk++; if (ctl_v2t_p !== 5'd14) begin n_err++; $display("FAIL step2_p: got %0d expected 14", ctl_v2t_p); end
        tick(4);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        n_chk++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL abort_flags: got %b expected 00", {busy, done}); end
        n_chk++; if (ctl_v2t_p !== 5'd14) begin n_err++; $display("FAIL abort_p: got %0d expected 14", ctl_v2t_p); end
        tick(12);
        n_chk++; if (ctl_v2t_p !== 5'd14 || busy !== 1'b0) begin n_err++; $display("FAIL abort_hold: got p=%0d busy=%b expected p=14 busy=0", ctl_v2t_p, busy); end
    endtask

    task automatic test_saturation();
        setup(0, 8'd20, 1'b1, 5'd0, 4'd2, 8'd3, 8'd4, 8'd0);
        kick();
        wait_done(40, cyc);
        n_chk++; if (cyc !== 10) begin n_err++; $display("FAIL sat_latency: got %0d expected 10", cyc); end
        n_chk++; if ({done, cal_err, busy} !== 3'b110) begin n_err++; $display("FAIL sat_flags: got %b expected 110", {done, cal_err, busy}); end
        n_chk++; if (ctl_v2t_p !== 5'd0) begin n_err++; $display("FAIL sat_p: got %0d expected 0", ctl_v2t_p); end
    endtask

    task automatic test_converge();
        setup(1, 8'd0, 1'b1, 5'd16, 4'd2, 8'd3, 8'd2, 8'd0);
        kick();
        wait_done(200, cyc);
        n_chk++; if (cyc !== 58) begin n_err++; $display("FAIL conv_latency: got %0d expected 58", cyc); end
        n_chk++; if (ctl_v2t_p !== 5'd10) begin n_err++; $display("FAIL conv_p: got %0d expected 10", ctl_v2t_p); end
        n_chk++; if ({done, cal_err} !== 2'b10) begin n_err++; $display("FAIL conv_flags: got %b expected 10", {done, cal_err}); end
        n_chk++; if (mean_out !== 9'd0) begin n_err++; $display("FAIL conv_mean: got %0d expected 0", mean_out); end
    endtask

    task automatic test_flip();
        setup(2, 8'd0, 1'b1, 5'd16, 4'd2, 8'd3, 8'd0, 8'd0);
        kick();
        wait_done(200, cyc);
        n_chk++; if (cyc !== 34) begin n_err++; $display("FAIL flip_latency: got %0d expected 34", cyc); end
        n_chk++; if ({done, cal_err} !== 2'b10) begin n_err++; $display("FAIL flip_flags: got %b expected 10", {done, cal_err}); end
        n_chk++; if (ctl_v2t_p !== 5'd16) begin n_err++; $display("FAIL flip_p: got %0d expected 16", ctl_v2t_p); end
        n_chk++; if (mean_out !== 9'h1EC) begin n_err++; $display("FAIL flip_mean: got %h expected 1ec", mean_out); end
    endtask

    task automatic test_iter_limit();
        setup(0, 8'd20, 1'b1, 5'd16, 4'd2, 8'd3, 8'd4, 8'd3);
        kick();
        wait_done(200, cyc);
        n_chk++; if (cyc !== 26) begin n_err++; $display("FAIL iter_latency: got %0d expected 26", cyc); end
        n_chk++; if ({done, cal_err} !== 2'b11) begin n_err++; $display("FAIL iter_flags: got %b expected 11", {done, cal_err}); end
        n_chk++; if (ctl_v2t_p !== 5'd13) begin n_err++; $display("FAIL iter_p: got %0d expected 13", ctl_v2t_p); end
    endtask

    task automatic test_long_avg();
        setup(0, 8'd255, 1'b1, 5'd16, 4'd15, 8'd0, 8'd255, 8'd0);
        kick();
        wait_done(1200, cyc);
        n_chk++; if (cyc !== 1027) begin n_err++; $display("FAIL long_latency: got %0d expected 1027", cyc); end
        n_chk++; if (mean_out !== 9'd255) begin n_err++; $display("FAIL long_mean: got %0d expected 255", mean_out); end
        n_chk++; if ({done, cal_err} !== 2'b10) begin n_err++; $display("FAIL long_flags: got %b expected 10", {done, cal_err}); end
    endtask

    task automatic test_async_reset();
        setup(0, 8'd20, 1'b1, 5'd16, 4'd2, 8'd3, 8'd4, 8'd0);
        kick();
        tick(2);
        n_chk++; if (busy !== 1'b1 || ctl_v2t_p !== 5'd16) begin n_err++; $display("FAIL pre_rst: got busy=%b p=%0d expected busy=1 p=16", busy, ctl_v2t_p); end
        rstb = 1'b0;
        #2;
        n_chk++; if ({ctl_v2t_p, ctl_v2t_n} !== 10'd0) begin n_err++; $display("FAIL async_codes: got p=%0d n=%0d expected 0 0", ctl_v2t_p, ctl_v2t_n); end
        n_chk++; if ({busy, done, cal_err} !== 3'b000 || mean_out !== 9'd0) begin n_err++; $display("FAIL async_flags: got %b mean=%0d expected 000 mean=0", {busy, done, cal_err}, mean_out); end
        tick(1);
        rstb = 1'b1;
        tick(3);
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %b expected 0", busy); end
    endtask

    initial begin
        n_err = 0; n_chk = 0;
        start = 1'b0; abort = 1'b0; rstb = 1'b0;
        setup(0, 8'd0, 1'b1, 5'd0, 4'd0, 8'd0, 8'd0, 8'd0);
        test_reset();
        test_constant_step();
        test_saturation();
        test_converge();
        test_flip();
        test_iter_limit();
        test_long_avg();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
